// File: rtl/freq_div_pkg.sv
// Shared types and helpers for the multi-channel clock-enable divider.
// Divide ratios are clamped on the widest supported width (16 bits), and the callers narrow the result.
package freq_div_pkg;

    typedef enum logic [1:0] {
        SQUARE = 2'b00,
        PULSE  = 2'b01,
        INV    = 2'b10,
        RSVD   = 2'b11
    } freq_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } chan_state_e;

    localparam int unsigned MAX_DW = 16;

    // Idle output level for each mode. Bit n of this vector is the level for mode value n.
    localparam logic [3:0] IDLE_LVL = 4'b0100;

    function automatic logic [MAX_DW-1:0] clamp_div(input logic [MAX_DW-1:0] d);
        return (d < MAX_DW'(2)) ? MAX_DW'(2) : d;
    endfunction

    function automatic logic idle_level(input freq_mode_e m);
        return IDLE_LVL[m];
    endfunction

endpackage

// File: rtl/freq_div_chan.sv
// One divider channel. It holds a counter, shadow ratio/mode registers, waveform decode and a tick flop.
// state    | meaning
// ST_IDLE  | counter held at 0, out = idle level of the input mode, no tick
// ST_RUN   | counter cycles 0..N-1, shadows reload only on the wrap edge
module freq_div_chan
    import freq_div_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] div,
    input  logic [1:0]    mode,
    output logic          out,
    output logic          tick
);

    localparam logic [DW-1:0] ONE = DW'(1);

    chan_state_e   state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] n_q, n_d;
    freq_mode_e    mode_q, mode_d;
    logic          out_q, out_d;
    logic          tick_q, tick_d;

    logic [DW-1:0] div_eff;
    freq_mode_e    mode_in;

    assign div_eff = DW'(clamp_div(MAX_DW'(div)));
    assign mode_in = freq_mode_e'(mode);

    // The high length is ceil(n/2), computed without n+1 so that n = 2^DW-1 cannot overflow.
    function automatic logic wave(input logic [DW-1:0] c, input logic [DW-1:0] n,
                                  input freq_mode_e m);
        logic [DW-1:0] half;
        half = (n >> 1) + DW'(n[0]);
        case (m)
            PULSE:   return c == '0;
            INV:     return !(c < half);
            default: return c < half;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        mode_d  = mode_q;
        out_d   = out_q;
        tick_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en) begin
                    state_d = ST_RUN;
                    n_d     = div_eff;
                    mode_d  = mode_in;
                    out_d   = wave('0, div_eff, mode_in);
                end else begin
                    out_d = idle_level(mode_in);
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    out_d   = idle_level(mode_in);
                end else if (cnt_q == n_q - ONE) begin
                    cnt_d  = '0;
                    n_d    = div_eff;
                    mode_d = mode_in;
                    out_d  = wave('0, div_eff, mode_in);
                end else begin
                    cnt_d  = cnt_q + ONE;
                    out_d  = wave(cnt_d, n_q, mode_q);
                    tick_d = (cnt_d == n_q - ONE);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            mode_q  <= SQUARE;
            out_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            tick_q  <= tick_d;
        end
    end

    assign out  = out_q;
    assign tick = tick_q;

endmodule

// File: rtl/freq_div_multi.sv
// NCH independent divider channels. The top only slices the packed ratio/mode buses.
module freq_div_multi #(
    parameter int unsigned DW  = 8,
    parameter int unsigned NCH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*DW-1:0] div,
    input  logic [NCH*2-1:0]  mode,
    output logic [NCH-1:0]    out,
    output logic [NCH-1:0]    tick
);

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        freq_div_chan #(.DW(DW)) u_chan (
            .clk  (clk),
            .rst  (rst),
            .en   (en[c]),
            .div  (div[c*DW +: DW]),
            .mode (mode[c*2 +: 2]),
            .out  (out[c]),
            .tick (tick[c])
        );
    end

endmodule

// File: tb/tb_freq_div_multi.sv
// Directed bench for freq_div_multi with DW=8 and NCH=2. Expected waveforms are hand-written strings, one character per cycle.
module tb_freq_div_multi;

    localparam int unsigned DW  = 8;
    localparam int unsigned NCH = 2;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    en;
    logic [NCH*DW-1:0] div;
    logic [NCH*2-1:0]  mode;
    logic [NCH-1:0]    out;
    logic [NCH-1:0]    tick;

    int n_assert = 0;
    int n_fail   = 0;

    freq_div_multi #(.DW(DW), .NCH(NCH)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .div  (div),
        .mode (mode),
        .out  (out),
        .tick (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input string s, input int i);
        if (i >= s.len()) return 1'b0;
        return s[i] == "1";
    endfunction

    // Advance one cycle per character and check both channels. A short or empty string means 0 for the remaining cycles.
    task automatic run(input string tag, input int len, input string eo0, input string et0,
                       input string eo1, input string et1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk($sformatf("%s c%0d out0", tag, i), 32'(out[0]), 32'(bit_at(eo0, i)));
            chk($sformatf("%s c%0d tick0", tag, i), 32'(tick[0]), 32'(bit_at(et0, i)));
            chk($sformatf("%s c%0d out1", tag, i), 32'(out[1]), 32'(bit_at(eo1, i)));
            chk($sformatf("%s c%0d tick1", tag, i), 32'(tick[1]), 32'(bit_at(et1, i)));
        end
    endtask

    task automatic idle0(input string tag);
        en[0] = 1'b0;
        run(tag, 1, "0", "0", "", "");
    endtask

    int highs;
    int ticks;

    initial begin
        rst  = 1'b1;
        en   = '0;
        div  = '0;
        mode = {2'b00, 2'b10};
        run("reset", 2, "", "", "", "");

        rst = 1'b0;
        run("inv_idle", 1, "1", "0", "", "");

        mode[1:0] = 2'b00;
        div[7:0]  = 8'd4;
        en[0]     = 1'b1;
        run("sq4", 8, "11001100", "00010001", "", "");

        run("chg_pre", 2, "11", "00", "", "");
        div[7:0] = 8'd6;
        run("chg_post", 14, "00111000111000", "01000001000001", "", "");

        idle0("idle_a");
        div[7:0] = 8'd8;
        en[0]    = 1'b1;
        run("n8_start", 3, "111", "000", "", "");
        en[0] = 1'b0;
        run("n8_drop", 2, "00", "00", "", "");
        en[0] = 1'b1;
        run("n8_reen", 8, "11110000", "00000001", "", "");

        idle0("idle_b");
        div[7:0] = 8'd5;
        en[0]    = 1'b1;
        run("sq5", 10, "1110011100", "0000100001", "", "");

        idle0("idle_c");
        div[7:0]  = 8'd3;
        mode[1:0] = 2'b01;
        en[0]     = 1'b1;
        run("pulse3", 6, "100100", "001001", "", "");

        en[0]     = 1'b0;
        mode[1:0] = 2'b00;
        run("idle_d", 1, "0", "0", "", "");
        div[7:0] = 8'd0;
        en[0]    = 1'b1;
        run("div0", 4, "1010", "0101", "", "");
        idle0("idle_e");
        div[7:0] = 8'd1;
        en[0]    = 1'b1;
        run("div1", 4, "1010", "0101", "", "");

        idle0("idle_f");
        div[7:0] = 8'd255;
        en[0]    = 1'b1;
        highs    = 0;
        ticks    = 0;
        for (int i = 0; i < 255; i++) begin
            @(negedge clk);
            if (i == 0) chk("div255 first out", 32'(out[0]), 32'd1);
            highs += int'(out[0]);
            ticks += int'(tick[0]);
        end
        chk("div255 highs", 32'(highs), 32'd128);
        chk("div255 ticks", 32'(ticks), 32'd1);
        chk("div255 last tick", 32'(tick[0]), 32'd1);
        run("div255 wrap", 1, "1", "0", "", "");

        idle0("idle_g");
        div  = {8'd7, 8'd6};
        mode = {2'b00, 2'b10};
        en   = 2'b11;
        run("pre_rst", 3, "000", "000", "111", "000");
        rst = 1'b1;
        run("mid_rst", 2, "", "", "", "");
        rst = 1'b0;
        run("post_rst", 12, "000111000111", "000001000001", "111100011110", "000000100000");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
